// File: rtl/ram_test_ctrl.sv
// Word-wide RAM march test: writes P(a) = {6'b0,a}^SEED over a range, reads back and counts mismatches.
// Define RAM_TEST_INV_PASS_EN to add a second write/read pass using ~P(a).
module ram_test_ctrl #(
    parameter logic [25:0] ADDR_FIRST = 26'h0000000,
    parameter logic [25:0] ADDR_LAST  = 26'h3FFFFFC,
    parameter logic [31:0] SEED       = 32'hA5C3_0F96
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    output logic        ram_en,
    output logic        ram_wr,
    output logic [1:0]  ram_size,
    output logic [25:0] ram_addr,
    output logic [31:0] ram_data_out,
    input  logic [31:0] ram_data_in,
    input  logic        ram_wt,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic [15:0] err_count,
    output logic [25:0] err_addr
);

    localparam logic [25:0] A_FIRST = {ADDR_FIRST[25:2], 2'b00};
    localparam logic [25:0] A_LAST  = {ADDR_LAST[25:2], 2'b00};

    // IDLE: waiting, or armed for one cycle when busy | WRITE/READ: pattern pass | DONE: results held
`ifdef RAM_TEST_INV_PASS_EN
    typedef enum logic [2:0] {IDLE, WRITE, READ, DONE, WRITE_INV, READ_INV} state_t;
`else
    typedef enum logic [1:0] {IDLE, WRITE, READ, DONE} state_t;
`endif

    function automatic logic [31:0] f_pat(input logic [25:0] a, input logic inv);
        logic [31:0] p;
        p = {6'b0, a} ^ SEED;
        return inv ? ~p : p;
    endfunction

    state_t      r_state, w_state_nxt;
    logic        r_en, w_en_nxt;
    logic        r_wr, w_wr_nxt;
    logic [25:0] r_addr, w_addr_nxt;
    logic [31:0] r_data, w_data_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_done, w_done_nxt;
    logic        r_pass, w_pass_nxt;
    logic [15:0] r_err_cnt, w_err_cnt_nxt;
    logic [25:0] r_err_addr, w_err_addr_nxt;

    logic        w_ack;
    logic        w_last;
    logic        w_inv;
    logic        w_mis;
    logic [25:0] w_addr_inc;
    logic [15:0] w_err_cnt_upd;
    logic [25:0] w_err_addr_upd;

`ifdef RAM_TEST_INV_PASS_EN
    assign w_inv = (r_state == WRITE_INV) || (r_state == READ_INV);
`else
    assign w_inv = 1'b0;
`endif

    assign w_ack          = r_en & ~ram_wt;
    assign w_last         = (r_addr == A_LAST);
    assign w_addr_inc     = r_addr + 26'd4;
    assign w_mis          = (ram_data_in != f_pat(r_addr, w_inv));
    assign w_err_cnt_upd  = (w_mis && r_err_cnt != 16'hFFFF) ? r_err_cnt + 16'd1 : r_err_cnt;
    assign w_err_addr_upd = (w_mis && r_err_cnt == 16'd0) ? r_addr : r_err_addr;

    always_comb begin
        w_state_nxt    = r_state;
        w_en_nxt       = r_en;
        w_wr_nxt       = r_wr;
        w_addr_nxt     = r_addr;
        w_data_nxt     = r_data;
        w_busy_nxt     = r_busy;
        w_done_nxt     = r_done;
        w_pass_nxt     = r_pass;
        w_err_cnt_nxt  = r_err_cnt;
        w_err_addr_nxt = r_err_addr;
        case (r_state)
            IDLE, DONE: begin
                if (r_busy) begin
                    w_state_nxt = WRITE;
                    w_en_nxt    = 1'b1;
                    w_wr_nxt    = 1'b1;
                    w_addr_nxt  = A_FIRST;
                    w_data_nxt  = f_pat(A_FIRST, 1'b0);
                end else if (start) begin
                    w_state_nxt    = IDLE;
                    w_busy_nxt     = 1'b1;
                    w_done_nxt     = 1'b0;
                    w_pass_nxt     = 1'b0;
                    w_err_cnt_nxt  = 16'd0;
                    w_err_addr_nxt = 26'd0;
                    w_addr_nxt     = A_FIRST;
                end
            end
            WRITE: begin
                if (w_ack) begin
                    if (w_last) begin
                        w_state_nxt = READ;
                        w_wr_nxt    = 1'b0;
                        w_addr_nxt  = A_FIRST;
                    end else begin
                        w_addr_nxt = w_addr_inc;
                        w_data_nxt = f_pat(w_addr_inc, 1'b0);
                    end
                end
            end
            READ: begin
                if (w_ack) begin
                    w_err_cnt_nxt  = w_err_cnt_upd;
                    w_err_addr_nxt = w_err_addr_upd;
                    if (w_last) begin
`ifdef RAM_TEST_INV_PASS_EN
                        w_state_nxt = WRITE_INV;
                        w_wr_nxt    = 1'b1;
                        w_addr_nxt  = A_FIRST;
                        w_data_nxt  = f_pat(A_FIRST, 1'b1);
`else
                        w_state_nxt = DONE;
                        w_en_nxt    = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_cnt_upd == 16'd0);
`endif
                    end else begin
                        w_addr_nxt = w_addr_inc;
                    end
                end
            end
`ifdef RAM_TEST_INV_PASS_EN
            WRITE_INV: begin
                if (w_ack) begin
                    if (w_last) begin
                        w_state_nxt = READ_INV;
                        w_wr_nxt    = 1'b0;
                        w_addr_nxt  = A_FIRST;
                    end else begin
                        w_addr_nxt = w_addr_inc;
                        w_data_nxt = f_pat(w_addr_inc, 1'b1);
                    end
                end
            end
            READ_INV: begin
                if (w_ack) begin
                    w_err_cnt_nxt  = w_err_cnt_upd;
                    w_err_addr_nxt = w_err_addr_upd;
                    if (w_last) begin
                        w_state_nxt = DONE;
                        w_en_nxt    = 1'b0;
                        w_busy_nxt  = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_pass_nxt  = (w_err_cnt_upd == 16'd0);
                    end else begin
                        w_addr_nxt = w_addr_inc;
                    end
                end
            end
`endif
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_en       <= 1'b0;
            r_wr       <= 1'b0;
            r_addr     <= A_FIRST;
            r_data     <= 32'd0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_pass     <= 1'b0;
            r_err_cnt  <= 16'd0;
            r_err_addr <= 26'd0;
        end else begin
            r_state    <= w_state_nxt;
            r_en       <= w_en_nxt;
            r_wr       <= w_wr_nxt;
            r_addr     <= w_addr_nxt;
            r_data     <= w_data_nxt;
            r_busy     <= w_busy_nxt;
            r_done     <= w_done_nxt;
            r_pass     <= w_pass_nxt;
            r_err_cnt  <= w_err_cnt_nxt;
            r_err_addr <= w_err_addr_nxt;
        end
    end

    assign ram_en       = r_en;
    assign ram_wr       = r_wr;
    assign ram_size     = 2'b10;
    assign ram_addr     = r_addr;
    assign ram_data_out = r_data;
    assign busy         = r_busy;
    assign done         = r_done;
    assign pass         = r_pass;
    assign err_count    = r_err_cnt;
    assign err_addr     = r_err_addr;

endmodule

// File: tb/tb_ram_test_ctrl.sv
// Scoreboard bench for ram_test_ctrl: a RAM model with random waits and fault injection,
// an expected-access/result queue built from the pattern rules, and a negedge monitor.
module tb_ram_test_ctrl;

    localparam logic [31:0] SEED  = 32'hA5C3_0F96;
    localparam int          FIRST = 0;
    localparam int          LAST  = 'h3C;
    localparam int          NW    = (LAST - FIRST) / 4 + 1;
`ifdef RAM_TEST_INV_PASS_EN
    localparam int NPASS = 2;
`else
    localparam int NPASS = 1;
`endif

    typedef struct {
        bit          wr;
        logic [25:0] addr;
        logic [31:0] data;
    } acc_t;
    typedef struct {
        logic [15:0] cnt;
        logic [25:0] ea;
        bit          ps;
    } res_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic        ram_en, ram_wr, busy, done, pass;
    logic [1:0]  ram_size;
    logic [25:0] ram_addr, err_addr;
    logic [31:0] ram_data_out;
    logic [31:0] ram_data_in = 32'd0;
    logic        ram_wt = 1'b0;
    logic [15:0] err_count;

    logic        start1 = 1'b0;
    logic        ram_en1, ram_wr1, busy1, done1, pass1;
    logic [1:0]  ram_size1;
    logic [25:0] ram_addr1, err_addr1;
    logic [31:0] ram_data_out1;
    logic [31:0] ram_data_in1 = 32'd0;
    logic        ram_wt1 = 1'b0;
    logic [15:0] err_count1;

    acc_t        exp_q[$];
    res_t        res_q[$];
    logic [31:0] mem[logic [25:0]];
    int          n_cmp = 0;
    int          n_fail = 0;
    int          fault_mode = 0;
    int          max_wait = 0;
    bit          in_acc = 1'b0;
    int          rem = 0;
    bit          prev_done = 1'b0;
    bit          w8_set = 1'b0;
    logic [31:0] w8_data = 32'd0;
    logic [31:0] w0_last = 32'd0;
    int          nw1 = 0, nr1 = 0, bad1 = 0;
    logic [31:0] d1_first = 32'd0;

    always #5 clk = ~clk;

    ram_test_ctrl #(.ADDR_FIRST(26'(FIRST)), .ADDR_LAST(26'(LAST)), .SEED(SEED)) dut (
        .clk(clk), .reset(reset), .start(start),
        .ram_en(ram_en), .ram_wr(ram_wr), .ram_size(ram_size), .ram_addr(ram_addr),
        .ram_data_out(ram_data_out), .ram_data_in(ram_data_in), .ram_wt(ram_wt),
        .busy(busy), .done(done), .pass(pass), .err_count(err_count), .err_addr(err_addr)
    );

    ram_test_ctrl #(.ADDR_FIRST(26'h100), .ADDR_LAST(26'h100), .SEED(SEED)) dut1 (
        .clk(clk), .reset(reset), .start(start1),
        .ram_en(ram_en1), .ram_wr(ram_wr1), .ram_size(ram_size1), .ram_addr(ram_addr1),
        .ram_data_out(ram_data_out1), .ram_data_in(ram_data_in1), .ram_wt(ram_wt1),
        .busy(busy1), .done(done1), .pass(pass1), .err_count(err_count1), .err_addr(err_addr1)
    );

    function automatic logic [31:0] pat(input logic [25:0] a, input bit inv);
        logic [31:0] p;
        p = {6'b0, a} ^ SEED;
        return inv ? ~p : p;
    endfunction

    // Fault models applied to read data: 1 = bit0 flipped at 0x10/0x20, 2 = bit31 stuck at 0.
    function automatic logic [31:0] fault(input logic [25:0] a, input logic [31:0] d);
        if (fault_mode == 1 && (a == 26'h10 || a == 26'h20)) return d ^ 32'h1;
        if (fault_mode == 2) return d & 32'h7FFF_FFFF;
        return d;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic build_expect();
        res_t r;
        r.cnt = 0;
        r.ea  = 0;
        for (int p = 0; p < NPASS; p++) begin
            for (int a = FIRST; a <= LAST; a += 4)
                exp_q.push_back('{1'b1, 26'(a), pat(26'(a), p[0])});
            for (int a = FIRST; a <= LAST; a += 4) begin
                exp_q.push_back('{1'b0, 26'(a), 32'd0});
                if (fault(26'(a), pat(26'(a), p[0])) != pat(26'(a), p[0])) begin
                    if (r.cnt == 0) r.ea = 26'(a);
                    if (r.cnt != 16'hFFFF) r.cnt++;
                end
            end
        end
        r.ps = (r.cnt == 0);
        res_q.push_back(r);
    endtask

    // RAM model: decides wait/data for the cycle after each edge.
    always begin
        @(posedge clk);
        #1;
        if (reset || !ram_en) begin
            ram_wt = 1'b0;
            in_acc = 1'b0;
        end else begin
            if (!in_acc) begin
                in_acc = 1'b1;
                rem    = int'($urandom_range(max_wait, 0));
            end
            if (rem > 0) begin
                ram_wt = 1'b1;
                rem--;
            end else begin
                ram_wt = 1'b0;
                in_acc = 1'b0;
                if (ram_wr) mem[ram_addr] = ram_data_out;
                else ram_data_in = mem.exists(ram_addr) ? fault(ram_addr, mem[ram_addr]) : 32'hDEAD_BEEF;
            end
        end
    end

    // Monitor: every active request cycle must match the head of the expected-access queue.
    always @(negedge clk) begin
        acc_t h;
        res_t r;
        if (reset) begin
            prev_done = 1'b0;
        end else begin
            if (ram_en) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_access", 1, 0);
                end else begin
                    h = exp_q[0];
                    check("acc_wr", ram_wr, h.wr);
                    check("acc_addr", ram_addr, h.addr);
                    if (h.wr) check("acc_data", ram_data_out, h.data);
                    if (!ram_wt) begin
                        check("acc_size", ram_size, 2'b10);
                        void'(exp_q.pop_front());
                        if (ram_wr && ram_addr == 26'h8 && !w8_set) begin
                            w8_set  = 1'b1;
                            w8_data = ram_data_out;
                        end
                        if (ram_wr && ram_addr == 26'h0) w0_last = ram_data_out;
                    end
                end
            end
            if (done && !prev_done) begin
                if (res_q.size() == 0) begin
                    check("unexpected_done", 1, 0);
                end else begin
                    r = res_q.pop_front();
                    check("err_count", err_count, r.cnt);
                    check("err_addr", err_addr, r.ea);
                    check("pass", pass, r.ps);
                    check("busy_at_done", busy, 0);
                    check("en_at_done", ram_en, 0);
                end
            end
            prev_done = done;
        end
    end

    // Ideal single-cycle RAM for the one-word instance.
    always @(negedge clk) begin
        if (!reset && ram_en1) begin
            if (ram_addr1 != 26'h100) bad1++;
            if (ram_wr1) begin
                if (nw1 == 0) d1_first = ram_data_out1;
                nw1++;
                ram_data_in1 = ram_data_out1;
            end else begin
                nr1++;
            end
        end
    end

    task automatic run(input int mode, input int mw, input bit extra);
        int cyc;
        fault_mode = mode;
        max_wait   = mw;
        mem.delete();
        w8_set = 1'b0;
        build_expect();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        while (!done && cyc < 4000) begin
            start = extra && (cyc % 5 == 2) && (cyc < 20);
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        if (!done) check("done_timeout", 0, 1);
        else if (mw == 0) check("latency", cyc, 2 + NPASS * 2 * NW);
        @(negedge clk);
        check("exp_q_empty", exp_q.size(), 0);
        check("res_q_empty", res_q.size(), 0);
    endtask

    initial begin
        int cyc;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_en", ram_en, 0);
        check("rst_wr", ram_wr, 0);
        check("rst_addr", ram_addr, FIRST);
        check("rst_data", ram_data_out, 0);
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_pass", pass, 0);
        check("rst_errcnt", err_count, 0);
        check("rst_erraddr", err_addr, 0);
        check("rst_addr1", ram_addr1, 26'h100);

        run(0, 0, 1'b1);
        check("wdata_addr8", w8_data, 32'hA5C3_0F9E);
`ifdef RAM_TEST_INV_PASS_EN
        check("inv_wdata_addr0", w0_last, 32'h5A3C_F069);
`endif
        check("pass_held", pass, 1);
        run(0, 5, 1'b1);
        run(1, 5, 1'b0);
        run(2, 0, 1'b0);

        // Reset while a read is stalled.
        fault_mode = 0;
        max_wait   = 5;
        mem.delete();
        build_expect();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc   = 0;
        while (!(ram_en && !ram_wr && ram_wt) && cyc < 4000) begin
            @(negedge clk);
            cyc++;
        end
        check("reach_read_wait", ram_en && !ram_wr && ram_wt, 1);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("mid_rst_en", ram_en, 0);
        check("mid_rst_wr", ram_wr, 0);
        check("mid_rst_busy", busy, 0);
        check("mid_rst_done", done, 0);
        check("mid_rst_errcnt", err_count, 0);
        check("mid_rst_addr", ram_addr, FIRST);
        @(negedge clk);
        exp_q.delete();
        res_q.delete();
        reset = 1'b0;
        run(0, 3, 1'b0);

        // Single-word range with redundant starts.
        nw1 = 0;
        nr1 = 0;
        bad1 = 0;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b1;
        @(negedge clk);
        start1 = 1'b0;
        cyc = 0;
        while (!done1 && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        check("one_done", done1, 1);
        repeat (3) @(negedge clk);
        check("one_writes", nw1, NPASS);
        check("one_reads", nr1, NPASS);
        check("one_bad_addr", bad1, 0);
        check("one_wdata", d1_first, pat(26'h100, 1'b0));
        check("one_errcnt", err_count1, 0);
        check("one_pass", pass1, 1);
        check("one_idle_en", ram_en1, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
